// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: request/ack memory-style bus; master issues req/we/addr/wdata, slave returns rdata/ack
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer memory between video prefetch and a host port
// Ports: clk, rst_n (async, active-low); frame_start_i, pix_rd_i from the video timing;
// pixel_o / underflow_o to the display; host (slave bus from the host); mem (master bus to memory).
module vga_fb_arbiter #(
  parameter int RES_X      = 640,
  parameter int RES_Y      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_i,
  input  logic             pix_rd_i,
  output logic [31:0]      pixel_o,
  output logic             underflow_o,
  vga_fb_arbiter_if.slave  host,
  vga_fb_arbiter_if.master mem
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(RES_X * RES_Y);
  localparam logic [LW-1:0]   LOW   = LW'(LOW_WATER);
  localparam logic [LW-1:0]   FULL  = LW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, VID, HOST} state_t;
  state_t            state_q;
  logic [ADDR_W:0]   vid_addr_q, vid_addr_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d, lvl;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]       pixel_q, host_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q, vid_next;
  logic              underflow_q, discard_q, host_ack_q, mem_req_q, mem_we_q;
  logic              vid_left, host_pend, take_vid, take_host, push, pop;
  // A frame_start seen in IDLE already counts as a flushed FIFO at address 0,
  // so the fetch issued that cycle belongs to the new frame.
  // host_ack_q masks the host request still held high in its own ack cycle.
  always_comb begin
    vid_left   = frame_start_i || (vid_addr_q < TOTAL);
    vid_next   = frame_start_i ? '0 : vid_addr_q[ADDR_W-1:0];
    lvl        = frame_start_i ? '0 : level_q;
    host_pend  = host.req && !host_ack_q;
    take_vid   = vid_left && (lvl <= LOW || (!host_pend && lvl < FULL));
    take_host  = host_pend && !take_vid;
    push       = state_q == VID && mem.ack && !discard_q && !frame_start_i;
    pop        = pix_rd_i && level_q != '0 && !frame_start_i;
    vid_addr_d = frame_start_i ? '0 : vid_addr_q + (ADDR_W+1)'(push);
    level_d    = frame_start_i ? '0 : level_q + LW'(push) - LW'(pop);
    wr_ptr_d   = frame_start_i ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = frame_start_i ? '0 : rd_ptr_q + PW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vid_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pixel_q      <= '0;
      underflow_q  <= 1'b0;
      discard_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if (state_q == IDLE && take_vid) begin
        state_q    <= VID;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= vid_next;
      end else if (state_q == IDLE && take_host) begin
        state_q     <= HOST;
        mem_req_q   <= 1'b1;
        mem_we_q    <= host.we;
        mem_addr_q  <= host.addr;
        mem_wdata_q <= host.wdata;
      end else if (state_q != IDLE && mem.ack) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end
      // A fetch cut across a frame boundary still finishes on the bus; its data is dropped.
      discard_q    <= state_q == VID && !mem.ack && (discard_q || frame_start_i);
      host_ack_q   <= state_q == HOST && mem.ack;
      host_rdata_q <= state_q == HOST && mem.ack && !mem_we_q ? mem.rdata : host_rdata_q;
      vid_addr_q   <= vid_addr_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pixel_q      <= frame_start_i ? '0 : pix_rd_i ? (level_q != '0 ? fifo_q[rd_ptr_q] : '0) : pixel_q;
      underflow_q  <= !frame_start_i && (underflow_q || (pix_rd_i && level_q == '0));
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem.rdata;
  end
  assign pixel_o     = pixel_q;
  assign underflow_o = underflow_q;
  assign host.ack    = host_ack_q;
  assign host.rdata  = host_rdata_q;
  assign mem.req     = mem_req_q;
  assign mem.we      = mem_we_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;
endmodule
